// File: rtl/snoopy_bus_arbiter_pkg.sv
// Shared types for the snoopy bus arbiter: arbitration state encoding and index-width helper.
package snoopy_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_MEM,
    ARB_RESP
  } arb_stat_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snoopy_bus_arbiter_rr_picker.sv
// Round-robin picker: first eligible master at or after rr_ptr, searched cyclically.
module snoopy_bus_arbiter_rr_picker
  import snoopy_bus_arbiter_pkg::*;
#(
  parameter int N    = 2,
  parameter int IDXW = idx_width(N)
) (
  input  logic [N-1:0]    eligible,
  input  logic [IDXW-1:0] rr_ptr,
  output logic [IDXW-1:0] grant,
  output logic            any_valid
);

  logic [IDXW:0]   sum;
  logic [IDXW-1:0] idx;

  // Walk offsets from farthest to nearest so the closest eligible master wins.
  always_comb begin
    grant     = rr_ptr;
    any_valid = |eligible;
    sum       = '0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDXW + 1)'(k);
      if (sum >= (IDXW + 1)'(N)) begin
        sum = sum - (IDXW + 1)'(N);
      end
      idx = sum[IDXW-1:0];
      if (eligible[idx]) begin
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/snoopy_bus_arbiter.sv
// Round-robin arbiter of cache ports onto one memory port, with write-invalidate broadcast.
// Invalidation engine is built only when SNOOPY_BUS_INV_EN is defined.
module snoopy_bus_arbiter
  import snoopy_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int WIDTH       = 128,
  parameter int MASKW       = WIDTH / 8,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_rw_valid,
  input  logic [NUM_MASTERS-1:0]            m_rw_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_rw_addr,
  input  logic [NUM_MASTERS*MASKW-1:0]      m_w_mask,
  input  logic [NUM_MASTERS*WIDTH-1:0]      m_w_data,
  input  logic [NUM_MASTERS-1:0]            m_w_ce,
  output logic [NUM_MASTERS-1:0]            m_rw_ready,
  output logic [WIDTH-1:0]                  m_r_data,
  output logic [NUM_MASTERS-1:0]            m_inv_valid,
  output logic [ADDR_WIDTH-1:0]             m_inv_addr,
  input  logic [NUM_MASTERS-1:0]            m_inv_ready,
  output logic                              mem_valid,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [MASKW-1:0]                  mem_wmask,
  output logic [WIDTH-1:0]                  mem_wdata,
  output logic                              mem_ce,
  input  logic                              mem_ready,
  input  logic [WIDTH-1:0]                  mem_rdata
);

  localparam int IDXW = idx_width(NUM_MASTERS);

  arb_stat_t              state_reg, state_next;
  logic [IDXW-1:0]        grant_reg, rr_ptr_reg, pick;
  logic                   any_valid;
  logic                   we_reg, ce_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [MASKW-1:0]       mask_reg;
  logic [WIDTH-1:0]       data_reg, rdata_reg;
  logic                   inv_busy;
  logic [NUM_MASTERS-1:0] eligible, grant_onehot;

  // Writes wait while an invalidation is outstanding; reads never do.
  assign eligible = m_rw_valid & ~(m_rw_we & {NUM_MASTERS{inv_busy}});

  snoopy_bus_arbiter_rr_picker #(
    .N    (NUM_MASTERS),
    .IDXW (IDXW)
  ) u_rr_picker (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_reg),
    .grant     (pick),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ARB_IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      we_reg     <= 1'b0;
      ce_reg     <= 1'b0;
      addr_reg   <= '0;
      mask_reg   <= '0;
      data_reg   <= '0;
      rdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ARB_IDLE && any_valid) begin
        grant_reg  <= pick;
        we_reg     <= m_rw_we[pick];
        ce_reg     <= m_w_ce[pick];
        addr_reg   <= m_rw_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
        mask_reg   <= m_w_mask[pick*MASKW +: MASKW];
        data_reg   <= m_w_data[pick*WIDTH +: WIDTH];
        rr_ptr_reg <= (pick == IDXW'(NUM_MASTERS - 1)) ? '0 : pick + IDXW'(1);
      end
      if (state_reg == ARB_MEM && mem_ready) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_valid  = 1'b0;
    case (state_reg)
      ARB_IDLE: if (any_valid) state_next = ARB_MEM;
      ARB_MEM: begin
        mem_valid = 1'b1;
        if (mem_ready) state_next = ARB_RESP;
      end
      ARB_RESP: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
    assign grant_onehot[gi] = (grant_reg == IDXW'(gi));
    assign m_rw_ready[gi]   = (state_reg == ARB_RESP) && grant_onehot[gi];
  end

  assign m_r_data  = rdata_reg;
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wmask = mask_reg;
  assign mem_wdata = data_reg;
  assign mem_ce    = ce_reg;

`ifdef SNOOPY_BUS_INV_EN
  logic [NUM_MASTERS-1:0] inv_pend_reg;
  logic [ADDR_WIDTH-1:0]  inv_addr_reg;

  // A write can only be granted with inv_pend empty, so loading never overlaps clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_pend_reg <= '0;
      inv_addr_reg <= '0;
    end else if (state_reg == ARB_RESP && we_reg) begin
      inv_pend_reg <= ~grant_onehot;
      inv_addr_reg <= addr_reg;
    end else begin
      inv_pend_reg <= inv_pend_reg & ~m_inv_ready;
    end
  end

  assign inv_busy    = |inv_pend_reg;
  assign m_inv_valid = inv_pend_reg;
  assign m_inv_addr  = inv_addr_reg;
`else
  logic unused_inv_ready;

  assign unused_inv_ready = ^m_inv_ready;
  assign inv_busy         = 1'b0;
  assign m_inv_valid      = '0;
  assign m_inv_addr       = '0;
`endif

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Scoreboard bench for snoopy_bus_arbiter; invalidation tests follow SNOOPY_BUS_INV_EN.
module tb_snoopy_bus_arbiter;

  localparam int N  = 2;
  localparam int W  = 128;
  localparam int MW = 16;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_rw_valid = '0, m_rw_we = '0, m_w_ce = '0, m_inv_ready = '0;
  logic [N*AW-1:0] m_rw_addr = '0;
  logic [N*MW-1:0] m_w_mask = '0;
  logic [N*W-1:0]  m_w_data = '0;
  logic [N-1:0]    m_rw_ready, m_inv_valid;
  logic [W-1:0]    m_r_data, mem_wdata;
  logic [W-1:0]    mem_rdata = '0;
  logic [AW-1:0]   m_inv_addr, mem_addr;
  logic            mem_valid, mem_we, mem_ce;
  logic            mem_ready = 1'b0;
  logic [MW-1:0]   mem_wmask;

  snoopy_bus_arbiter #(
    .NUM_MASTERS (N),
    .WIDTH       (W),
    .MASKW       (MW),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_rw_valid  (m_rw_valid),
    .m_rw_we     (m_rw_we),
    .m_rw_addr   (m_rw_addr),
    .m_w_mask    (m_w_mask),
    .m_w_data    (m_w_data),
    .m_w_ce      (m_w_ce),
    .m_rw_ready  (m_rw_ready),
    .m_r_data    (m_r_data),
    .m_inv_valid (m_inv_valid),
    .m_inv_addr  (m_inv_addr),
    .m_inv_ready (m_inv_ready),
    .mem_valid   (mem_valid),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wmask   (mem_wmask),
    .mem_wdata   (mem_wdata),
    .mem_ce      (mem_ce),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int mem_wait = 0;
  int wait_cnt = 0;
  bit mem_hold = 1'b0;

  typedef struct {
    int           master;
    bit           is_write;
    logic [W-1:0] data;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [N-1:0] mon_rdy;

  function automatic logic [W-1:0] rdata_fn(input logic [AW-1:0] a);
    if (a == 32'h0000_1000) return {16{8'hAA}};
    return {4{a ^ 32'h5A5A_0000}};
  endfunction

  // Memory model: answers mem_valid after mem_wait extra cycles unless held off.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (mem_valid && !mem_hold) begin
      if (wait_cnt >= mem_wait) begin
        mem_ready = 1'b1;
        mem_rdata = rdata_fn(mem_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Scoreboard: every completion pulse must match the oldest expected transaction.
  always @(negedge clk) begin
    if (!rst && m_rw_ready !== '0) begin
      chk_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_ready: got m_rw_ready=%b, expected none", m_rw_ready);
      end else begin
        mon_e   = sb.pop_front();
        mon_rdy = '0;
        mon_rdy[mon_e.master] = 1'b1;
        if (m_rw_ready !== mon_rdy)
          $display("FAIL sb_grant_order: got m_rw_ready=%b, expected %b", m_rw_ready, mon_rdy);
        else
          pass_cnt++;
        if (!mon_e.is_write) begin
          chk_cnt++;
          if (m_r_data !== mon_e.data)
            $display("FAIL sb_read_data: got %h, expected %h", m_r_data, mon_e.data);
          else
            pass_cnt++;
        end
        $display("txn master=%0d %s data=%h", mon_e.master, mon_e.is_write ? "write" : "read",
                 m_r_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    m_rw_valid  = '0;
    m_inv_ready = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int m, input bit we, input logic [AW-1:0] a,
                         input logic [MW-1:0] mask, input logic [W-1:0] d, input bit ce);
    m_rw_we[m]              = we;
    m_rw_addr[m*AW +: AW]   = a;
    m_w_mask[m*MW +: MW]    = mask;
    m_w_data[m*W +: W]      = d;
    m_w_ce[m]               = ce;
    m_rw_valid[m]           = 1'b1;
  endtask

  // Returns the number of cycles until m_rw_ready[m], or -1 on timeout; drops the request.
  task automatic wait_ready(input int m, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (m_rw_ready[m]) begin
        cyc           = i;
        m_rw_valid[m] = 1'b0;
        return;
      end
    end
    m_rw_valid[m] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    tick();
    chk_cnt++; if (mem_valid !== 1'b0) $display("FAIL rst_mem_valid: got %b, expected 0", mem_valid); else pass_cnt++;
    chk_cnt++; if (m_rw_ready !== '0) $display("FAIL rst_rw_ready: got %b, expected 0", m_rw_ready); else pass_cnt++;
    chk_cnt++; if (m_inv_valid !== '0) $display("FAIL rst_inv_valid: got %b, expected 0", m_inv_valid); else pass_cnt++;
    chk_cnt++; if (m_r_data !== '0) $display("FAIL rst_r_data: got %h, expected 0", m_r_data); else pass_cnt++;
    chk_cnt++; if (mem_addr !== '0 || mem_wdata !== '0 || mem_wmask !== '0)
      $display("FAIL rst_mem_fields: got addr=%h data=%h mask=%h, expected 0", mem_addr, mem_wdata, mem_wmask);
    else pass_cnt++;
    chk_cnt++; if (m_inv_addr !== '0) $display("FAIL rst_inv_addr: got %h, expected 0", m_inv_addr); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    int cyc;
    bit inv_seen;
    set_req(0, 1'b0, 32'h0000_1000, '0, '0, 1'b0);
    sb.push_back('{0, 1'b0, {16{8'hAA}}});
    tick();
    chk_cnt++; if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_we !== 1'b0)
      $display("FAIL read_mem_req: got valid=%b addr=%h we=%b, expected 1 00001000 0", mem_valid, mem_addr, mem_we);
    else pass_cnt++;
    wait_ready(0, 20, cyc);
    chk_cnt++; if (cyc !== 1) $display("FAIL read_latency: got ready %0d cycles after mem_valid, expected 1", cyc); else pass_cnt++;
    chk_cnt++; if (m_r_data !== {16{8'hAA}}) $display("FAIL read_data: got %h, expected all AA", m_r_data); else pass_cnt++;
    inv_seen = 1'b0;
    repeat (4) begin
      tick();
      if (m_inv_valid !== '0) inv_seen = 1'b1;
    end
    chk_cnt++; if (inv_seen) $display("FAIL read_no_inv: got m_inv_valid activity, expected none"); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int cyc0, cyc1;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      set_req(0, 1'b0, 32'h0000_0100, '0, '0, 1'b0);
      set_req(1, 1'b0, 32'h0000_0200, '0, '0, 1'b0);
      sb.push_back('{0, 1'b0, rdata_fn(32'h0000_0100)});
      sb.push_back('{1, 1'b0, rdata_fn(32'h0000_0200)});
      wait_ready(0, 20, cyc0);
      wait_ready(1, 20, cyc1);
      chk_cnt++; if (cyc0 !== (pass == 0 ? 2 : 3))
        $display("FAIL rr_first_latency: pass %0d got %0d, expected %0d", pass, cyc0, pass == 0 ? 2 : 3);
      else pass_cnt++;
      chk_cnt++; if (cyc1 !== 3) $display("FAIL rr_second_gap: pass %0d got %0d, expected 3", pass, cyc1); else pass_cnt++;
    end
  endtask

  task automatic test_mem_wait();
    int cyc;
    tick();
    mem_wait = 2;
    set_req(1, 1'b0, 32'h0000_0300, '0, '0, 1'b0);
    sb.push_back('{1, 1'b0, rdata_fn(32'h0000_0300)});
    wait_ready(1, 20, cyc);
    chk_cnt++; if (cyc !== 4) $display("FAIL wait_latency: got %0d, expected 4", cyc); else pass_cnt++;
    mem_wait = 0;
  endtask

  task automatic test_reset_mid();
    bit rdy_seen;
    tick();
    mem_hold = 1'b1;
    set_req(0, 1'b0, 32'h0000_0400, '0, '0, 1'b0);
    tick();
    chk_cnt++; if (mem_valid !== 1'b1) $display("FAIL rmid_in_mem: got mem_valid=%b, expected 1", mem_valid); else pass_cnt++;
    rst        = 1'b1;
    m_rw_valid = '0;
    tick();
    chk_cnt++; if (mem_valid !== 1'b0 || m_rw_ready !== '0)
      $display("FAIL rmid_valid: got mem_valid=%b ready=%b, expected 0 0", mem_valid, m_rw_ready);
    else pass_cnt++;
    chk_cnt++; if (mem_addr !== '0 || m_r_data !== '0)
      $display("FAIL rmid_data: got addr=%h r_data=%h, expected 0", mem_addr, m_r_data);
    else pass_cnt++;
    rst      = 1'b0;
    mem_hold = 1'b0;
    rdy_seen = 1'b0;
    repeat (6) begin
      tick();
      if (m_rw_ready !== '0 || mem_valid !== 1'b0) rdy_seen = 1'b1;
    end
    chk_cnt++; if (rdy_seen) $display("FAIL rmid_no_ready: got activity after abort, expected idle"); else pass_cnt++;
  endtask

`ifdef SNOOPY_BUS_INV_EN
  task automatic test_write_invalidate();
    int cyc;
    tick();
    set_req(0, 1'b1, 32'h0000_2000, 16'hFFFF, {4{32'hDEAD_BEEF}}, 1'b1);
    sb.push_back('{0, 1'b1, '0});
    tick();
    chk_cnt++; if (mem_we !== 1'b1 || mem_addr !== 32'h0000_2000 || mem_wmask !== 16'hFFFF || mem_ce !== 1'b1)
      $display("FAIL wr_mem_req: got we=%b addr=%h mask=%h ce=%b, expected 1 00002000 ffff 1", mem_we, mem_addr, mem_wmask, mem_ce);
    else pass_cnt++;
    chk_cnt++; if (mem_wdata !== {4{32'hDEAD_BEEF}}) $display("FAIL wr_mem_data: got %h, expected deadbeef x4", mem_wdata); else pass_cnt++;
    wait_ready(0, 20, cyc);
    chk_cnt++; if (cyc !== 1) $display("FAIL wr_latency: got %0d, expected 1", cyc); else pass_cnt++;
    tick();
    chk_cnt++; if (m_inv_valid !== 2'b10 || m_inv_addr !== 32'h0000_2000)
      $display("FAIL inv_rise: got valid=%b addr=%h, expected 10 00002000", m_inv_valid, m_inv_addr);
    else pass_cnt++;
    tick();
    tick();
    m_inv_ready = 2'b11;
    chk_cnt++; if (m_inv_valid !== 2'b10) $display("FAIL inv_hold: got %b, expected 10", m_inv_valid); else pass_cnt++;
    tick();
    m_inv_ready = '0;
    chk_cnt++; if (m_inv_valid !== 2'b00) $display("FAIL inv_clear: got %b, expected 00", m_inv_valid); else pass_cnt++;
  endtask

  task automatic test_write_blocked();
    int  cyc;
    bit  granted;
    tick();
    set_req(0, 1'b1, 32'h0000_3000, 16'h00FF, {4{32'h1234_5678}}, 1'b0);
    sb.push_back('{0, 1'b1, '0});
    wait_ready(0, 20, cyc);
    set_req(0, 1'b1, 32'h0000_3100, 16'hFF00, {4{32'h8765_4321}}, 1'b0);
    set_req(1, 1'b0, 32'h0000_0500, '0, '0, 1'b0);
    sb.push_back('{1, 1'b0, rdata_fn(32'h0000_0500)});
    wait_ready(1, 20, cyc);
    chk_cnt++; if (cyc < 0) $display("FAIL blk_read_done: got timeout, expected read completion"); else pass_cnt++;
    granted = 1'b0;
    repeat (5) begin
      tick();
      if (mem_valid !== 1'b0) granted = 1'b1;
    end
    chk_cnt++; if (granted) $display("FAIL blk_write_held: got mem_valid=1, expected write blocked"); else pass_cnt++;
    sb.push_back('{0, 1'b1, '0});
    m_inv_ready = 2'b10;
    tick();
    m_inv_ready = '0;
    wait_ready(0, 20, cyc);
    chk_cnt++; if (cyc < 0) $display("FAIL blk_write_done: got timeout, expected grant after inv clear"); else pass_cnt++;
    tick();
    chk_cnt++; if (m_inv_valid !== 2'b10 || m_inv_addr !== 32'h0000_3100)
      $display("FAIL blk_inv2: got valid=%b addr=%h, expected 10 00003100", m_inv_valid, m_inv_addr);
    else pass_cnt++;
    m_inv_ready = 2'b10;
    tick();
    m_inv_ready = '0;
  endtask
`else
  task automatic test_no_inv();
    int cyc;
    bit inv_seen;
    tick();
    set_req(0, 1'b1, 32'h0000_2000, 16'hFFFF, {4{32'hCAFE_F00D}}, 1'b1);
    sb.push_back('{0, 1'b1, '0});
    tick();
    chk_cnt++; if (mem_we !== 1'b1 || mem_addr !== 32'h0000_2000 || mem_wmask !== 16'hFFFF)
      $display("FAIL ni_mem_req: got we=%b addr=%h mask=%h, expected 1 00002000 ffff", mem_we, mem_addr, mem_wmask);
    else pass_cnt++;
    wait_ready(0, 20, cyc);
    chk_cnt++; if (cyc !== 1) $display("FAIL ni_latency: got %0d, expected 1", cyc); else pass_cnt++;
    set_req(0, 1'b1, 32'h0000_2100, 16'h0F0F, {4{32'h0BAD_CAFE}}, 1'b0);
    sb.push_back('{0, 1'b1, '0});
    m_inv_ready = 2'b11;
    inv_seen    = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (m_inv_valid !== '0 || m_inv_addr !== '0) inv_seen = 1'b1;
      if (i == 3) begin
        chk_cnt++; if (m_rw_ready[0] !== 1'b1) $display("FAIL ni_write2_unblocked: got ready=%b, expected 01", m_rw_ready); else pass_cnt++;
      end
    end
    m_rw_valid[0] = 1'b0;
    m_inv_ready   = '0;
    chk_cnt++; if (inv_seen) $display("FAIL ni_inv_idle: got m_inv_valid/addr activity, expected 0"); else pass_cnt++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_mem_wait();
    test_reset_mid();
`ifdef SNOOPY_BUS_INV_EN
    test_write_invalidate();
    test_write_blocked();
`else
    test_no_inv();
`endif
    repeat (3) tick();
    chk_cnt++; if (sb.size() != 0) $display("FAIL sb_drained: got %0d outstanding, expected 0", sb.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/snoopy_bus_arbiter.md
# snoopy_bus_arbiter

- Shared bus stage directly downstream of the per-core snoopy read-only caches.
- Arbitrates NUM_MASTERS cache bus ports (refills and write-throughs) onto one memory port, round-robin.
- After every completed write, broadcasts an invalidation to every other master so stale lines are dropped.
- Invalidation runs in parallel with later reads, so a cache blocked in refill never deadlocks against a pending invalidate.

## Interface
- NUM_MASTERS, 2, number of cache ports (≥1)
- WIDTH, 128, data line width
- MASKW, WIDTH/8, byte-mask width
- ADDR_WIDTH, 32, address width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m_rw_valid  in  NUM_MASTERS  per-master request, held until m_rw_ready
- m_rw_we  in  NUM_MASTERS  1=write, 0=read
- m_rw_addr  in  NUM_MASTERS×ADDR_WIDTH  request address
- m_w_mask  in  NUM_MASTERS×MASKW  write byte mask
- m_w_data  in  NUM_MASTERS×WIDTH  write data
- m_w_ce  in  NUM_MASTERS  write cache-enable, forwarded
- m_rw_ready  out  NUM_MASTERS  one-cycle completion pulse
- m_r_data  out  WIDTH  read data, shared, valid with m_rw_ready
- m_inv_valid  out  NUM_MASTERS  invalidate request, held until m_inv_ready
- m_inv_addr  out  ADDR_WIDTH  invalidate address, shared
- m_inv_ready  in  NUM_MASTERS  invalidate acknowledge pulse
- mem_valid  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wmask  out  MASKW  memory byte mask
- mem_wdata  out  WIDTH  memory write data
- mem_ce  out  1  forwarded m_w_ce
- mem_ready  in  1  memory completion pulse
- mem_rdata  in  WIDTH  read data, valid with mem_ready

## Operation
- Arbitration FSM ARB_IDLE → ARB_MEM → ARB_RESP → ARB_IDLE.
- ARB_IDLE: eligible = m_rw_valid & ~(m_rw_we & {NUM_MASTERS{inv_busy}}).
  - Pick the first eligible master at or after rr_ptr, cyclic.
  - Register grant, we, addr, mask, data and ce; set rr_ptr = grant+1 (mod NUM_MASTERS); go ARB_MEM.
  - No eligible master: stay in ARB_IDLE.
- ARB_MEM: mem_valid=1 with the registered fields.
  - On mem_ready: latch mem_rdata into rdata_q and go ARB_RESP.
- ARB_RESP: m_rw_ready[grant]=1 and m_r_data=rdata_q.
  - On a write, load the invalidation engine: inv_addr_q=addr, inv_pend = all masters except grant, inv_busy = |inv_pend.
  - Go ARB_IDLE.
- Invalidation engine:
  - m_inv_valid = inv_pend (registered); m_inv_addr = inv_addr_q.
  - Bit i clears on the edge after m_inv_ready[i]=1; inv_busy drops when inv_pend reaches 0.
- While inv_busy: reads are still granted, including to masters with pending invalidates. A re-fetched line that is invalidated afterwards is a harmless extra miss.
- Writes are not granted while inv_busy, since only one invalidation is in flight.
- NUM_MASTERS=1: inv_pend is never set.
- m_inv_ready for a bit not pending is ignored; m_rw_valid dropped mid-transaction is ignored.

## Timing
- Reset values:
  - FSM=ARB_IDLE, rr_ptr=0, inv_pend=0.
  - All m_rw_ready, m_inv_valid and mem_valid deasserted.
  - m_r_data, m_inv_addr and the mem_* data outputs are 0.
- Read or write latency with zero-wait memory: request in cycle 0, mem_valid in cycle 1, m_rw_ready in cycle 2. Each memory wait cycle adds one.
- Back-to-back grants: at most one transaction every 3 cycles.
- m_inv_valid rises the cycle after the writer's m_rw_ready. It falls the cycle after m_inv_ready, so a cache returning to idle never re-samples it.
- Reset mid-transaction: immediate return to reset state; no m_rw_ready is issued for the aborted request.

## Configuration
- SNOOPY_BUS_INV_EN defined: invalidation engine as described.
- Undefined:
  - m_inv_valid tied 0, m_inv_addr tied 0, m_inv_ready ignored.
  - inv_busy constant 0, so writes are never blocked.
  - Caches give no coherence guarantee.

## Structure
- Shared package (common): arb_stat_t enum (ARB_IDLE, ARB_MEM, ARB_RESP).
- One sub-module: rr_picker. Inputs eligible vector and rr_ptr; outputs grant index and any-valid.

## Test plan
- Single read, master 0, addr 0x1000, mem_rdata 0xAA…AA, zero-wait:
  - m_rw_ready[0] in cycle 2 with m_r_data=0xAA…AA.
  - No m_inv_valid.
- Masters 0 and 1 read simultaneously after reset:
  - Master 0 granted first, master 1 next.
  - A second simultaneous pair is granted master 0, then master 1 (rr_ptr wrapped to 0).
- Master 0 writes 0x2000, mask 0xFFFF:
  - mem_we=1, mem_addr=0x2000.
  - m_inv_valid=2'b10 with m_inv_addr=0x2000 the cycle after m_rw_ready[0].
  - Bit clears one cycle after m_inv_ready[1].
- Invalidate pending and m_inv_ready withheld; master 0 writes while master 1 reads:
  - Read granted and completes.
  - Write waits until inv_pend=0.
- rst asserted in ARB_MEM with mem_ready never arriving: all outputs at reset values next cycle, and no m_rw_ready.
- Macro undefined: write by master 0 → m_inv_valid stays 0, and a following write is granted without waiting.
